// File: rtl/div_sign_ctrl_if.sv
// Purpose : execute-stage and divider-side signal bundle for div_sign_ctrl.
// Latency : n/a (wiring only).
// Backpressure: start is only honoured while the controller is idle; divider side uses a toggle handshake.
//
// Port summary
//   start/is_signed/is_word/dividend/divisor : request from execute stage
//   busy/done/quotient/remainder/div_error   : status and results to execute stage
//   div_denom/div_num/div_run_in             : operand magnitudes and request toggle to divider
//   div_run_out/div_q/div_r                  : completion toggle and unsigned results from divider
// The master modport is the surroundings (execute stage plus divider); slave is the controller.
interface div_sign_ctrl_if;
    logic        start;
    logic        is_signed;
    logic        is_word;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_error;
    logic [31:0] div_denom;
    logic [31:0] div_num;
    logic        div_run_in;
    logic        div_run_out;
    logic [31:0] div_q;
    logic [31:0] div_r;

    modport master (
        output start, is_signed, is_word, dividend, divisor,
        output div_run_out, div_q, div_r,
        input  busy, done, quotient, remainder, div_error,
        input  div_denom, div_num, div_run_in
    );

    modport slave (
        input  start, is_signed, is_word, dividend, divisor,
        input  div_run_out, div_q, div_r,
        output busy, done, quotient, remainder, div_error,
        output div_denom, div_num, div_run_in
    );
endinterface

// File: rtl/div_sign_ctrl.sv
// Purpose : DIV/IDIV front end - sign handling, divider toggle handshake, #DE fault detection.
// Latency : done L+3 cycles after the start edge (L = divider latency); 2 cycles for a zero divisor.
// Backpressure: start is ignored while busy and in the done cycle; the divider is never re-requested
//               until its previous run has completed (div_run_out == div_run_in).
//
// Ports: clk, rst_n (async active-low), bus (div_sign_ctrl_if.slave) carrying the execute-stage
// request/response signals and the divider operand/toggle/result signals.
module div_sign_ctrl #(
    parameter bit ALLOW_MIN_QUOT = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    div_sign_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_RESYNC,
        S_IDLE,
        S_PREP,
        S_WAIT,
        S_FIX
    } state_t;

    state_t state, state_nxt;

    // Operands registered in IDLE so the execute stage may change them afterwards.
    logic        op_signed;
    logic        op_word;
    logic [31:0] op_dvd;
    logic [15:0] op_dvs;

    logic        qneg;
    logic        rneg;
    logic        zerr;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    logic [31:0] denom_q;
    logic [31:0] num_q;
    logic        run_in_q;
    logic        done_q;
    logic        err_q;
    logic [15:0] quot_q;
    logic [15:0] rem_q;

    // FSM strobes
    logic accept;
    logic launch;
    logic capture;
    logic finish;

    // The divider is idle whenever the two toggles agree.
    logic run_idle;
    assign run_idle = (bus.div_run_out == run_in_q);

    // ---------------------------------------------------------------
    // PREP datapath: sign extension and magnitudes
    // ---------------------------------------------------------------
    logic        sd;
    logic        sv;
    logic [31:0] dvd_ext;
    logic [15:0] dvs_ext;
    logic [31:0] dvd_mag;
    logic [15:0] dvs_mag;
    logic        dvs_zero;

    always_comb begin
        sd       = op_signed & (op_word ? op_dvd[31] : op_dvd[15]);
        sv       = op_signed & (op_word ? op_dvs[15] : op_dvs[7]);
        // For unsigned operands sd/sv are 0, so byte mode zero-extends.
        dvd_ext  = op_word ? op_dvd : {{16{sd}}, op_dvd[15:0]};
        dvs_ext  = op_word ? op_dvs : {{8{sv}}, op_dvs[7:0]};
        // Two's complement negate; -2^31 maps onto itself, which is the correct unsigned magnitude.
        dvd_mag  = sd ? (~dvd_ext + 32'd1) : dvd_ext;
        dvs_mag  = sv ? (~dvs_ext + 16'd1) : dvs_ext;
        dvs_zero = (dvs_mag == 16'd0);
    end

    // ---------------------------------------------------------------
    // FIX datapath: overflow limits and sign restoration
    // ---------------------------------------------------------------
    logic [31:0] lim_pos;
    logic [31:0] lim_neg;
    logic [31:0] lim_uns;
    logic [31:0] limit;
    logic        ovf;
    logic [31:0] qs;
    logic [31:0] rs;
    logic        unused_hi;

    always_comb begin
        lim_pos = op_word ? 32'h0000_7FFF : 32'h0000_007F;
        // A negative quotient may reach -128/-32768 only on the 80186 flavour.
        lim_neg = ALLOW_MIN_QUOT ? (lim_pos + 32'd1) : lim_pos;
        lim_uns = op_word ? 32'h0000_FFFF : 32'h0000_00FF;
        if (!op_signed) begin
            limit = lim_uns;
        end else if (qneg) begin
            limit = lim_neg;
        end else begin
            limit = lim_pos;
        end
        ovf = zerr | (q_mag > limit);
        qs  = qneg ? (~q_mag + 32'd1) : q_mag;
        rs  = rneg ? (~r_mag + 32'd1) : r_mag;
    end

    // Upper halves are discarded by truncation to the 16-bit result width.
    assign unused_hi = ^{qs[31:16], rs[31:16]};

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        launch    = 1'b0;
        capture   = 1'b0;
        finish    = 1'b0;
        unique case (state)
            // A divider run may have been in flight when reset hit; wait for it to drain.
            S_RESYNC: begin
                if (run_idle) begin
                    state_nxt = S_IDLE;
                end
            end
            // done_q is high only in the first IDLE cycle; a start there is dropped.
            S_IDLE: begin
                if (bus.start && !done_q) begin
                    accept    = 1'b1;
                    state_nxt = S_PREP;
                end
            end
            // A zero divisor skips the divider and reports through FIX so both paths share the pulse logic.
            S_PREP: begin
                if (dvs_zero) begin
                    state_nxt = S_FIX;
                end else begin
                    launch    = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (run_idle) begin
                    capture   = 1'b1;
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                finish    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_RESYNC;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_signed <= 1'b0;
            op_word   <= 1'b0;
            op_dvd    <= 32'd0;
            op_dvs    <= 16'd0;
            qneg      <= 1'b0;
            rneg      <= 1'b0;
            zerr      <= 1'b0;
            q_mag     <= 32'd0;
            r_mag     <= 32'd0;
            denom_q   <= 32'd0;
            num_q     <= 32'd0;
            run_in_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            quot_q    <= 16'd0;
            rem_q     <= 16'd0;
        end else begin
            done_q <= finish;
            err_q  <= finish & ovf;

            if (accept) begin
                op_signed <= bus.is_signed;
                op_word   <= bus.is_word;
                op_dvd    <= bus.dividend;
                op_dvs    <= bus.divisor;
            end

            if (state == S_PREP) begin
                qneg <= sd ^ sv;
                rneg <= sd;
                zerr <= dvs_zero;
            end

            // Operands stay on div_denom/div_num until the next launch.
            if (launch) begin
                denom_q  <= dvd_mag;
                num_q    <= {16'd0, dvs_mag};
                run_in_q <= ~run_in_q;
            end

            if (capture) begin
                q_mag <= bus.div_q;
                r_mag <= bus.div_r;
            end

            // On a fault the architectural results are left untouched.
            if (finish && !ovf) begin
                quot_q <= op_word ? qs[15:0] : {8'd0, qs[7:0]};
                rem_q  <= op_word ? rs[15:0] : {8'd0, rs[7:0]};
            end
        end
    end

    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = done_q;
    assign bus.div_error  = err_q;
    assign bus.quotient   = quot_q;
    assign bus.remainder  = rem_q;
    assign bus.div_denom  = denom_q;
    assign bus.div_num    = num_q;
    assign bus.div_run_in = run_in_q;

endmodule

// File: tb/tb_div_sign_ctrl.sv
// Purpose : self-checking bench for div_sign_ctrl with a toggle-handshake divider model.
// Latency : divider model completes L=33 cycles after it sees a request toggle.
// Backpressure: n/a (bench).
module tb_div_sign_ctrl;

    localparam int L = 33;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_sign_ctrl_if d1();
    div_sign_ctrl_if d2();

    div_sign_ctrl #(.ALLOW_MIN_QUOT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(d1.slave));
    div_sign_ctrl #(.ALLOW_MIN_QUOT(1'b0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(d2.slave));

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        e;
    } exp_t;

    typedef struct packed {
        logic        s;
        logic        w;
        logic [31:0] dd;
        logic [15:0] dv;
    } vec_t;

    int checks = 0;
    int passed = 0;
    exp_t exp1[$];
    exp_t exp2[$];
    logic [15:0] prev1_q = 16'd0, prev1_r = 16'd0;
    logic [15:0] prev2_q = 16'd0, prev2_r = 16'd0;
    int done_cnt1 = 0;
    int toggles1 = 0;
    logic rin_prev1 = 1'b0;
    exp_t m1, m2;

    // ---------------- divider models (not reset, like the real divider) ----------------
    logic rout1 = 1'b0, dbusy1 = 1'b0;
    logic [5:0] dcnt1 = 6'd0;
    logic [31:0] da1 = 32'd0, db1 = 32'd0, q1 = 32'd0, r1 = 32'd0;
    assign d1.div_run_out = rout1;
    assign d1.div_q = q1;
    assign d1.div_r = r1;

    always @(posedge clk) begin
        if (!dbusy1) begin
            if (d1.div_run_in !== rout1) begin
                dbusy1 <= 1'b1;
                dcnt1  <= 6'd1;
                da1    <= d1.div_denom;
                db1    <= d1.div_num;
            end
        end else if (dcnt1 == 6'(L - 1)) begin
            rout1  <= ~rout1;
            dbusy1 <= 1'b0;
            q1     <= (db1 == 0) ? 32'hFFFF_FFFF : da1 / db1;
            r1     <= (db1 == 0) ? da1 : da1 % db1;
        end else begin
            dcnt1 <= dcnt1 + 6'd1;
        end
    end

    logic rout2 = 1'b0, dbusy2 = 1'b0;
    logic [5:0] dcnt2 = 6'd0;
    logic [31:0] da2 = 32'd0, db2 = 32'd0, q2 = 32'd0, r2 = 32'd0;
    assign d2.div_run_out = rout2;
    assign d2.div_q = q2;
    assign d2.div_r = r2;

    always @(posedge clk) begin
        if (!dbusy2) begin
            if (d2.div_run_in !== rout2) begin
                dbusy2 <= 1'b1;
                dcnt2  <= 6'd1;
                da2    <= d2.div_denom;
                db2    <= d2.div_num;
            end
        end else if (dcnt2 == 6'(L - 1)) begin
            rout2  <= ~rout2;
            dbusy2 <= 1'b0;
            q2     <= (db2 == 0) ? 32'hFFFF_FFFF : da2 / db2;
            r2     <= (db2 == 0) ? da2 : da2 % db2;
        end else begin
            dcnt2 <= dcnt2 + 6'd1;
        end
    end

    // ---------------- reference model: x86 DIV/IDIV semantics ----------------
    function automatic exp_t model(input logic s, input logic w, input logic [31:0] dd,
                                   input logic [15:0] dv, input bit allow,
                                   input logic [15:0] pq, input logic [15:0] pr);
        longint a, b, q, r, hi, lo;
        exp_t e;
        if (s) begin
            a  = w ? longint'(int'(dd)) : longint'(shortint'(dd[15:0]));
            b  = w ? longint'(shortint'(dv)) : longint'(byte'(dv[7:0]));
            hi = w ? 32767 : 127;
            lo = allow ? -(hi + 1) : -hi;
        end else begin
            a  = w ? longint'(dd) : longint'(dd[15:0]);
            b  = w ? longint'(dv) : longint'(dv[7:0]);
            hi = w ? 65535 : 255;
            lo = 0;
        end
        e.q = pq;
        e.r = pr;
        e.e = 1'b1;
        if (b != 0) begin
            q = a / b;
            r = a % b;
            if (q <= hi && q >= lo) begin
                e.e = 1'b0;
                e.q = w ? q[15:0] : {8'h00, q[7:0]};
                e.r = w ? r[15:0] : {8'h00, r[7:0]};
            end
        end
        return e;
    endfunction

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (d1.div_run_in !== rin_prev1) toggles1++;
        rin_prev1 = d1.div_run_in;
        if (rst_n === 1'b1 && d1.done === 1'b1) begin
            done_cnt1++;
            checks++;
            if (exp1.size() == 0) begin
                $display("FAIL dut1_unexpected_done: got done=1, expected no pending request");
            end else begin
                passed++;
                m1 = exp1.pop_front();
                checks++;
                if (d1.quotient !== m1.q) $display("FAIL dut1_quotient: got %h expected %h", d1.quotient, m1.q);
                else passed++;
                checks++;
                if (d1.remainder !== m1.r) $display("FAIL dut1_remainder: got %h expected %h", d1.remainder, m1.r);
                else passed++;
                checks++;
                if (d1.div_error !== m1.e) $display("FAIL dut1_div_error: got %b expected %b", d1.div_error, m1.e);
                else passed++;
                checks++;
                if (d1.busy !== 1'b0) $display("FAIL dut1_busy_at_done: got %b expected 0", d1.busy);
                else passed++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && d2.done === 1'b1) begin
            checks++;
            if (exp2.size() == 0) begin
                $display("FAIL dut2_unexpected_done: got done=1, expected no pending request");
            end else begin
                passed++;
                m2 = exp2.pop_front();
                checks++;
                if (d2.quotient !== m2.q) $display("FAIL dut2_quotient: got %h expected %h", d2.quotient, m2.q);
                else passed++;
                checks++;
                if (d2.div_error !== m2.e) $display("FAIL dut2_div_error: got %b expected %b", d2.div_error, m2.e);
                else passed++;
            end
        end
    end

    // ---------------- stimulus helper (no checking) ----------------
    task automatic issue(input logic s, input logic w, input logic [31:0] dd,
                         input logic [15:0] dv, output int lat);
        exp_t e;
        e = model(s, w, dd, dv, 1'b1, prev1_q, prev1_r);
        if (!e.e) begin
            prev1_q = e.q;
            prev1_r = e.r;
        end
        exp1.push_back(e);
        d1.is_signed = s;
        d1.is_word   = w;
        d1.dividend  = dd;
        d1.divisor   = dv;
        d1.start     = 1'b1;
        @(posedge clk); #1;
        d1.start     = 1'b0;
        d1.dividend  = $urandom;
        d1.divisor   = 16'($urandom);
        d1.is_signed = 1'($urandom_range(0, 1));
        d1.is_word   = 1'($urandom_range(0, 1));
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (d1.done === 1'b1) begin
                lat = n;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        checks++; if (d1.busy !== 1'b1) $display("FAIL rst_busy: got %b expected 1", d1.busy); else passed++;
        checks++; if (d1.done !== 1'b0) $display("FAIL rst_done: got %b expected 0", d1.done); else passed++;
        checks++; if (d1.div_error !== 1'b0) $display("FAIL rst_err: got %b expected 0", d1.div_error); else passed++;
        checks++; if (d1.quotient !== 16'd0) $display("FAIL rst_quot: got %h expected 0", d1.quotient); else passed++;
        checks++; if (d1.remainder !== 16'd0) $display("FAIL rst_rem: got %h expected 0", d1.remainder); else passed++;
        checks++; if (d1.div_run_in !== 1'b0) $display("FAIL rst_run_in: got %b expected 0", d1.div_run_in); else passed++;
        checks++; if (d1.div_denom !== 32'd0) $display("FAIL rst_denom: got %h expected 0", d1.div_denom); else passed++;
        checks++; if (d1.div_num !== 32'd0) $display("FAIL rst_num: got %h expected 0", d1.div_num); else passed++;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (d1.busy !== 1'b0) $display("FAIL rst_idle_dut1: busy got %b expected 0", d1.busy); else passed++;
        checks++; if (d2.busy !== 1'b0) $display("FAIL rst_idle_dut2: busy got %b expected 0", d2.busy); else passed++;
    endtask

    task automatic test_unsigned_word();
        int lat;
        issue(1'b0, 1'b1, 32'h0001_0000, 16'h0003, lat);
        checks++; if (lat !== 36) $display("FAIL uword_latency: got %0d expected 36", lat); else passed++;
    endtask

    task automatic test_patterns();
        vec_t v[6];
        int lat;
        v[0] = {1'b1, 1'b0, 32'hABCD_FF9C, 16'h5507};  // -100 / 7 byte
        v[1] = {1'b1, 1'b1, 32'hFFFE_7960, 16'h0007};  // -100000 / 7
        v[2] = {1'b1, 1'b0, 32'h0000_0064, 16'h00F9};  // 100 / -7 byte
        v[3] = {1'b0, 1'b0, 32'h1234_03E8, 16'hAA0A};  // 1000 / 10 byte
        v[4] = {1'b1, 1'b1, 32'hFFFF_FC17, 16'hFFE7};  // -1001 / -25
        v[5] = {1'b0, 1'b1, 32'hFFFE_FFFF, 16'hFFFF};  // quotient exactly 0xFFFF
        for (int i = 0; i < 6; i++) begin
            issue(v[i].s, v[i].w, v[i].dd, v[i].dv, lat);
            checks++;
            if (lat !== 36) $display("FAIL pattern%0d_latency: got %0d expected 36", i, lat);
            else passed++;
        end
    endtask

    task automatic test_div_zero();
        int lat, t0;
        t0 = toggles1;
        issue(1'b1, 1'b1, 32'h1234_5678, 16'h0000, lat);
        checks++; if (lat !== 2) $display("FAIL zero_word_latency: got %0d expected 2", lat); else passed++;
        issue(1'b0, 1'b0, 32'h0000_0042, 16'hFF00, lat);
        checks++; if (lat !== 2) $display("FAIL zero_byte_latency: got %0d expected 2", lat); else passed++;
        checks++;
        if (toggles1 !== t0) $display("FAIL zero_no_toggle: got %0d toggles expected 0", toggles1 - t0);
        else passed++;
    endtask

    task automatic test_overflow();
        vec_t v[6];
        int lat;
        v[0] = {1'b0, 1'b1, 32'h0001_0000, 16'h0001};  // 65536 -> error
        v[1] = {1'b1, 1'b1, 32'hFFFF_8000, 16'h0001};  // -32768 legal
        v[2] = {1'b1, 1'b0, 32'h0000_FF80, 16'h0001};  // -128 legal
        v[3] = {1'b1, 1'b0, 32'h0000_FF80, 16'h00FF};  // +128 -> error
        v[4] = {1'b1, 1'b1, 32'h8000_0000, 16'hFFFF};  // +2^31 -> error
        v[5] = {1'b0, 1'b0, 32'h0000_0100, 16'h0001};  // 256 -> error
        for (int i = 0; i < 6; i++) begin
            issue(v[i].s, v[i].w, v[i].dd, v[i].dv, lat);
            checks++;
            if (lat !== 36) $display("FAIL ovf%0d_latency: got %0d expected 36", i, lat);
            else passed++;
        end
    endtask

    task automatic test_min_quot_strict();
        vec_t v[2];
        exp_t e;
        int lat;
        v[0] = {1'b1, 1'b1, 32'hFFFF_8000, 16'h0001};  // -32768 faults on 8086 flavour
        v[1] = {1'b1, 1'b1, 32'h0000_7FFF, 16'h0001};
        for (int i = 0; i < 2; i++) begin
            e = model(v[i].s, v[i].w, v[i].dd, v[i].dv, 1'b0, prev2_q, prev2_r);
            if (!e.e) begin
                prev2_q = e.q;
                prev2_r = e.r;
            end
            exp2.push_back(e);
            d2.is_signed = v[i].s;
            d2.is_word   = v[i].w;
            d2.dividend  = v[i].dd;
            d2.divisor   = v[i].dv;
            d2.start     = 1'b1;
            @(posedge clk); #1;
            d2.start = 1'b0;
            lat = -1;
            for (int n = 1; n <= 200; n++) begin
                @(posedge clk); #1;
                if (d2.done === 1'b1) begin
                    lat = n;
                    break;
                end
            end
            @(posedge clk); #1;
            checks++;
            if (lat !== 36) $display("FAIL strict%0d_latency: got %0d expected 36", i, lat);
            else passed++;
        end
    endtask

    task automatic test_busy_start();
        exp_t e;
        int t0, c0, lat;
        t0 = toggles1;
        c0 = done_cnt1;
        e = model(1'b1, 1'b1, 32'hFFFF_FC17, 16'h0019, 1'b1, prev1_q, prev1_r);
        if (!e.e) begin
            prev1_q = e.q;
            prev1_r = e.r;
        end
        exp1.push_back(e);
        d1.is_signed = 1'b1;
        d1.is_word   = 1'b1;
        d1.dividend  = 32'hFFFF_FC17;
        d1.divisor   = 16'h0019;
        d1.start     = 1'b1;
        @(posedge clk); #1;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            d1.start = (n == 1 || n == 10 || n == 30) ? 1'b1 : 1'b0;
            if (n > 1) begin
                d1.dividend = 32'h0000_0001;
                d1.divisor  = 16'h0001;
            end
            @(posedge clk); #1;
            if (d1.done === 1'b1) begin
                lat = n;
                break;
            end
        end
        // start raised in the done cycle must be dropped
        d1.start = 1'b1;
        @(posedge clk); #1;
        d1.start = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        checks++; if (lat !== 36) $display("FAIL busy_latency: got %0d expected 36", lat); else passed++;
        checks++; if (toggles1 - t0 !== 1) $display("FAIL busy_toggles: got %0d expected 1", toggles1 - t0); else passed++;
        checks++; if (done_cnt1 - c0 !== 1) $display("FAIL busy_done_count: got %0d expected 1", done_cnt1 - c0); else passed++;
        checks++; if (d1.busy !== 1'b0) $display("FAIL busy_final_idle: got %b expected 0", d1.busy); else passed++;
    endtask

    task automatic test_reset_mid_wait();
        int lat, seen, bad;
        // The request below must flip run_in from 1 to 0 so that reset leaves a visible stray run.
        if (d1.div_run_in !== 1'b1) issue(1'b0, 1'b1, 32'h0000_0064, 16'h000A, lat);
        d1.is_signed = 1'b0;
        d1.is_word   = 1'b1;
        d1.dividend  = 32'h0001_0000;
        d1.divisor   = 16'h0003;
        d1.start     = 1'b1;
        @(posedge clk); #1;
        d1.start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        checks++; if (d1.busy !== 1'b1) $display("FAIL mid_busy_before: got %b expected 1", d1.busy); else passed++;
        rst_n = 1'b0;
        exp1.delete();
        prev1_q = 16'd0;
        prev1_r = 16'd0;
        #1;
        checks++; if (d1.busy !== 1'b1) $display("FAIL mid_rst_busy: got %b expected 1", d1.busy); else passed++;
        checks++; if (d1.quotient !== 16'd0) $display("FAIL mid_rst_quot: got %h expected 0", d1.quotient); else passed++;
        checks++; if (d1.remainder !== 16'd0) $display("FAIL mid_rst_rem: got %h expected 0", d1.remainder); else passed++;
        checks++; if (d1.div_run_in !== 1'b0) $display("FAIL mid_rst_run_in: got %b expected 0", d1.div_run_in); else passed++;
        checks++; if (d1.div_denom !== 32'd0) $display("FAIL mid_rst_denom: got %h expected 0", d1.div_denom); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        bad = 0;
        for (int n = 0; n < 100; n++) begin
            if (d1.div_run_out === d1.div_run_in) break;
            if (d1.busy !== 1'b1) bad++;
            seen++;
            @(posedge clk); #1;
        end
        checks++; if (bad !== 0) $display("FAIL mid_resync_busy: got %0d idle cycles expected 0", bad); else passed++;
        checks++; if (seen == 0 || seen >= 100) $display("FAIL mid_stray_run: got %0d cycles expected 1..%0d", seen, L); else passed++;
        @(posedge clk); #1;
        checks++; if (d1.busy !== 1'b0) $display("FAIL mid_resync_exit: busy got %b expected 0", d1.busy); else passed++;
        issue(1'b0, 1'b1, 32'h0000_0064, 16'h000A, lat);
        checks++; if (lat !== 36) $display("FAIL mid_after_latency: got %0d expected 36", lat); else passed++;
    endtask

    initial begin
        d1.start = 1'b0; d1.is_signed = 1'b0; d1.is_word = 1'b0; d1.dividend = 32'd0; d1.divisor = 16'd0;
        d2.start = 1'b0; d2.is_signed = 1'b0; d2.is_word = 1'b0; d2.dividend = 32'd0; d2.divisor = 16'd0;
        test_reset();
        test_unsigned_word();
        test_patterns();
        test_div_zero();
        test_overflow();
        test_min_quot_strict();
        test_busy_start();
        test_reset_mid_wait();
        repeat (3) @(posedge clk);
        checks++;
        if (exp1.size() != 0 || exp2.size() != 0)
            $display("FAIL pending_results: got %0d/%0d outstanding expected 0/0", exp1.size(), exp2.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish before 300000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_sign_ctrl.md
# div_sign_ctrl

Front-end controller for the CPU's DIV/IDIV execution path. It sits between the execute stage and the 32/32 unsigned iterative divider. It converts byte or word, signed or unsigned operands into unsigned magnitudes and drives the divider's toggle handshake. It then restores quotient and remainder signs and reports divide faults (zero divisor, quotient overflow) using 80186 semantics.

## Interface
Parameters:
- ALLOW_MIN_QUOT, 1: 1 = signed quotient of exactly −128 / −32768 is legal (80186); 0 = faults (8086).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- is_signed  in  1  1 = IDIV, 0 = DIV
- is_word  in  1  1 = DX:AX / r16, 0 = AX / r8
- dividend  in  32  {DX,AX}; byte mode uses [15:0]
- divisor  in  16  byte mode uses [7:0]
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, results valid
- quotient  out  16  byte mode: [7:0] valid, [15:8]=0
- remainder  out  16  byte mode: [7:0] valid, [15:8]=0
- div_error  out  1  valid with done; #DE fault
- div_denom  out  32  divider dividend magnitude
- div_num  out  32  divider divisor magnitude (zero-extended)
- div_run_in  out  1  divider request toggle
- div_run_out  in  1  divider completion toggle
- div_q, div_r  in  32  divider results

## Operation
- Divider protocol:
  - Divider is busy while div_run_in != div_run_out.
  - Request = toggle div_run_in with div_denom/div_num stable.
  - div_denom/div_num are held until completion.
  - Completion = div_run_out becomes equal to div_run_in; div_q/div_r are valid from then on.
- States: RESYNC, IDLE, PREP, WAIT, FIX.
  - RESYNC: reset state. Go to IDLE once div_run_out == div_run_in, which covers a divider left running across reset.
  - IDLE: on start, register operands and go to PREP.
- PREP:
  - Sign-extend per mode.
  - Magnitudes: |dividend| (byte: 16-bit, word: 32-bit) and |divisor|. Magnitude of −2^31 is 0x8000_0000.
  - Record qneg = sd^sv and rneg = sd, where sd and sv are the operand signs.
  - Divisor magnitude == 0: set div_error, pulse done, return to IDLE. The divider is not started.
  - Otherwise load div_denom/div_num, toggle div_run_in, go to WAIT.
- WAIT: capture div_q/div_r when div_run_out == div_run_in, go to FIX.
- FIX, overflow check on the unsigned quotient magnitude Q:
  - Unsigned: error if Q > 0xFF (byte) or Q > 0xFFFF (word).
  - Signed, qneg = 0: error if Q > 127 / 32767.
  - Signed, qneg = 1: error if Q > 128 / 32768. With ALLOW_MIN_QUOT = 0 the limit is 127 / 32767.
- FIX, outputs:
  - No error: quotient = qneg ? −Q : Q; remainder = rneg ? −R : R; both truncated to mode width.
  - Error: quotient/remainder keep their previous values.
  - Pulse done, return to IDLE.
- start outside IDLE is ignored. Operand inputs are only sampled in IDLE.

## Timing
- Reset values: state RESYNC, busy 1, done 0, div_error 0, quotient 0, remainder 0, div_run_in 0, div_denom 0, div_num 0.
- With a divider latency of L cycles (run_in toggle to run_out toggle; 33 for the current divider):
  - Normal path: done goes high L+3 cycles after the edge that samples start, i.e. 36 cycles.
  - Zero-divisor path: done goes high 2 cycles after the start edge.
- done and div_error are high for exactly one cycle, coincident with busy falling. busy is low in the following cycle.
- start may be asserted in the cycle done is high and is ignored. It is accepted from the next cycle.
- Reset mid-WAIT: outputs go to reset values immediately. The block stays in RESYNC (busy = 1) until the divider's stray run finishes, at most L cycles.

## Test plan
- Unsigned word: dividend 0x0001_0000, divisor 0x0003 → quotient 0x5555, remainder 0x0001, div_error 0; done exactly 36 cycles after start.
- Signed byte: dividend 0xFF9C (−100), divisor 0x07 → quotient 0x00F2, remainder 0x00FE, div_error 0.
- Divisor 0, any mode → done plus div_error after 2 cycles; div_run_in never toggles; quotient/remainder unchanged.
- Overflow:
  - Unsigned word 0x0001_0000 / 0x0001 → div_error 1.
  - Signed word 0xFFFF_8000 / 0x0001 → quotient 0x8000, no error with ALLOW_MIN_QUOT = 1; div_error 1 with ALLOW_MIN_QUOT = 0.
- Reset asserted 10 cycles into WAIT → busy stays 1 until div_run_out == div_run_in. A following 0x0000_0064 / 0x000A returns quotient 0x000A, remainder 0x0000.
- start pulses during busy and in the done cycle → no extra divider toggle; exactly one done per accepted start.
